// File: rtl/cpu_mem_cycle_seq_if.sv
//------------------------------------------------------------------------------
// cpu_mem_cycle_seq_if
//
// Purpose:
//   Bundles the request, memory-handshake and statistics signals between the
//   ND-120 microcode/MMU side and the memory-cycle sequencer.
//
// Signals:
//   Requests in : MREQ_REQ, RW_REQ, FETCH_REQ (microcode request)
//   Status in   : HIT (cache), MEM_RDY_n (bus ready), DVACC_n (DMA owns bus)
//   Outputs     : ACCEPT, DONE (one-tick pulses), MREQ_n, FETCH, WRITE, DT_n,
//                 FMISS, STP, IOXERR_n (CPU handshake), HIT_CNT, MISS_CNT
//
// Modports:
//   master : the environment (microcode decoder, MMU, bus)
//   slave  : the sequencer
//------------------------------------------------------------------------------
interface cpu_mem_cycle_seq_if;
    logic        MREQ_REQ;
    logic        RW_REQ;
    logic        FETCH_REQ;
    logic        HIT;
    logic        MEM_RDY_n;
    logic        DVACC_n;

    logic        ACCEPT;
    logic        DONE;
    logic        MREQ_n;
    logic        FETCH;
    logic        WRITE;
    logic        DT_n;
    logic        FMISS;
    logic        STP;
    logic        IOXERR_n;
    logic [15:0] HIT_CNT;
    logic [15:0] MISS_CNT;

    modport master (
        output MREQ_REQ, RW_REQ, FETCH_REQ, HIT, MEM_RDY_n, DVACC_n,
        input  ACCEPT, DONE, MREQ_n, FETCH, WRITE, DT_n, FMISS, STP, IOXERR_n,
        input  HIT_CNT, MISS_CNT
    );

    modport slave (
        input  MREQ_REQ, RW_REQ, FETCH_REQ, HIT, MEM_RDY_n, DVACC_n,
        output ACCEPT, DONE, MREQ_n, FETCH, WRITE, DT_n, FMISS, STP, IOXERR_n,
        output HIT_CNT, MISS_CNT
    );
endinterface

// File: rtl/cpu_mem_cycle_seq.sv
//------------------------------------------------------------------------------
// cpu_mem_cycle_seq
//
// Purpose:
//   Memory-cycle sequencer for the ND-120 CPU board. Takes one microcode
//   memory request at a time, runs a cache lookup, and on a miss or any write
//   runs a bus cycle guarded by a timeout. The CPU is stalled (STP) for the
//   duration of a bus cycle. Read hits finish without a stall.
//
// Ports:
//   sysclk     in  system clock
//   sys_rst_n  in  asynchronous active-low reset
//   CYC_EN     in  microcycle enable; every state/output change needs CYC_EN=1
//   MR_n       in  synchronous active-low master clear (qualified by CYC_EN)
//   bus        slave modport of cpu_mem_cycle_seq_if (requests, handshake,
//              statistics)
//
// Parameters:
//   TIMEOUT_CYCLES  enabled ticks spent in BUS before the cycle aborts (2..255)
//   CNT_W           width of the timeout counter
//
// Optional feature (macro CPU_MEM_CYCLE_STATS_EN):
//   Defined   : HIT_CNT / MISS_CNT count read hits and bus-going lookups,
//               saturating at 0xFFFF, cleared only by sys_rst_n.
//   Undefined : HIT_CNT / MISS_CNT are tied to zero.
//------------------------------------------------------------------------------
module cpu_mem_cycle_seq #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic                sysclk,
    input  logic                sys_rst_n,
    input  logic                CYC_EN,
    input  logic                MR_n,
    cpu_mem_cycle_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_BUS,
        S_XFER,
        S_FIN,
        S_ERR
    } state_t;

    // Counter value on the last BUS tick before the cycle is abandoned.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept_q, accept_d;
    logic             done_q, done_d;
    logic             mreq_n_q, mreq_n_d;
    logic             fetch_q, fetch_d;
    logic             write_q, write_d;
    logic             dt_n_q, dt_n_d;
    logic             fmiss_q, fmiss_d;
    logic             stp_q, stp_d;
    logic             ioxerr_n_q, ioxerr_n_d;

    // A read hit is the only lookup outcome that skips the bus; writes are
    // always written through even when the line is present.
    logic lookup_hit;
    assign lookup_hit = bus.HIT && !write_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept_d   = accept_q;
        done_d     = done_q;
        mreq_n_d   = mreq_n_q;
        fetch_d    = fetch_q;
        write_d    = write_q;
        dt_n_d     = dt_n_q;
        fmiss_d    = fmiss_q;
        stp_d      = stp_q;
        ioxerr_n_d = ioxerr_n_q;

        // With CYC_EN low everything holds, so single-tick pulses stretch
        // until the next enabled edge and the CPU sees them in its own cycle.
        if (CYC_EN) begin
            accept_d   = 1'b0;
            done_d     = 1'b0;
            ioxerr_n_d = 1'b1;
            dt_n_d     = 1'b1;

            if (!MR_n) begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                mreq_n_d = 1'b1;
                fetch_d  = 1'b0;
                write_d  = 1'b0;
                fmiss_d  = 1'b0;
                stp_d    = 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // DMA ownership of the bus holds the request off.
                        if (bus.MREQ_REQ && bus.DVACC_n) begin
                            accept_d = 1'b1;
                            write_d  = bus.RW_REQ;
                            fetch_d  = bus.FETCH_REQ;
                            mreq_n_d = 1'b0;
                            state_d  = S_LOOKUP;
                        end
                    end

                    S_LOOKUP: begin
                        if (lookup_hit) begin
                            dt_n_d  = 1'b0;
                            state_d = S_XFER;
                        end else begin
                            stp_d   = 1'b1;
                            fmiss_d = fetch_q;
                            cnt_d   = '0;
                            state_d = S_BUS;
                        end
                    end

                    S_BUS: begin
                        cnt_d = cnt_q + CNT_W'(1);
                        // Ready is checked first so a ready arriving on the
                        // expiry tick still completes the cycle.
                        if (!bus.MEM_RDY_n) begin
                            dt_n_d  = 1'b0;
                            state_d = S_XFER;
                        end else if (cnt_q == CNT_LAST) begin
                            ioxerr_n_d = 1'b0;
                            mreq_n_d   = 1'b1;
                            stp_d      = 1'b0;
                            fmiss_d    = 1'b0;
                            state_d    = S_ERR;
                        end
                    end

                    S_XFER: begin
                        // Outputs are registered, so FIN's values are loaded
                        // on the edge that enters FIN.
                        done_d   = 1'b1;
                        mreq_n_d = 1'b1;
                        stp_d    = 1'b0;
                        fmiss_d  = 1'b0;
                        state_d  = S_FIN;
                    end

                    S_FIN: begin
                        state_d = S_IDLE;
                    end

                    S_ERR: begin
                        state_d = S_IDLE;
                    end

                    default: begin
                        state_d  = S_IDLE;
                        mreq_n_d = 1'b1;
                        stp_d    = 1'b0;
                        fmiss_d  = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            accept_q   <= 1'b0;
            done_q     <= 1'b0;
            mreq_n_q   <= 1'b1;
            fetch_q    <= 1'b0;
            write_q    <= 1'b0;
            dt_n_q     <= 1'b1;
            fmiss_q    <= 1'b0;
            stp_q      <= 1'b0;
            ioxerr_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            accept_q   <= accept_d;
            done_q     <= done_d;
            mreq_n_q   <= mreq_n_d;
            fetch_q    <= fetch_d;
            write_q    <= write_d;
            dt_n_q     <= dt_n_d;
            fmiss_q    <= fmiss_d;
            stp_q      <= stp_d;
            ioxerr_n_q <= ioxerr_n_d;
        end
    end

    assign bus.ACCEPT   = accept_q;
    assign bus.DONE     = done_q;
    assign bus.MREQ_n   = mreq_n_q;
    assign bus.FETCH    = fetch_q;
    assign bus.WRITE    = write_q;
    assign bus.DT_n     = dt_n_q;
    assign bus.FMISS    = fmiss_q;
    assign bus.STP      = stp_q;
    assign bus.IOXERR_n = ioxerr_n_q;

`ifdef CPU_MEM_CYCLE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Statistics survive master clear; only the board reset clears them.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (CYC_EN && MR_n && (state_q == S_LOOKUP)) begin
            if (lookup_hit) begin
                hit_cnt_d = sat_inc16(hit_cnt_q);
            end else begin
                miss_cnt_d = sat_inc16(miss_cnt_q);
            end
        end
    end

    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.HIT_CNT  = hit_cnt_q;
    assign bus.MISS_CNT = miss_cnt_q;
`else
    assign bus.HIT_CNT  = 16'h0000;
    assign bus.MISS_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_mem_cycle_seq.sv
module tb_cpu_mem_cycle_seq;
    localparam int T = 6;
`ifdef CPU_MEM_CYCLE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // Per-transaction summary; ticks count clock edges from the request being
    // presented (first edge = tick 1). 8'hFF means "never happened".
    typedef struct packed {
        logic [7:0]  acc_t, dt_t, done_t, err_t, dt_cnt;
        logic        stall, fmiss, wr_ok, idle_mreq_n, idle_stp;
        logic [15:0] hit_cnt, miss_cnt;
    } res_t;

    logic sysclk;
    logic sys_rst_n;
    logic CYC_EN;
    logic MR_n;

    cpu_mem_cycle_seq_if bus_if();

    cpu_mem_cycle_seq #(
        .TIMEOUT_CYCLES(T),
        .CNT_W(8)
    ) dut (
        .sysclk   (sysclk),
        .sys_rst_n(sys_rst_n),
        .CYC_EN   (CYC_EN),
        .MR_n     (MR_n),
        .bus      (bus_if)
    );

    int   checks   = 0;
    int   errors   = 0;
    int   exp_hit  = 0;
    int   exp_miss = 0;
    res_t sb[$];

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "simulation time limit");
    end

    // {ACCEPT, DONE, MREQ_n, FETCH, WRITE, DT_n, FMISS, STP, IOXERR_n}
    function automatic logic [8:0] outs();
        return {bus_if.ACCEPT, bus_if.DONE, bus_if.MREQ_n, bus_if.FETCH, bus_if.WRITE,
                bus_if.DT_n, bus_if.FMISS, bus_if.STP, bus_if.IOXERR_n};
    endfunction

    function automatic logic [15:0] cnt16(input int v);
        return STATS ? 16'(v) : 16'h0000;
    endfunction

    // Reference model of one transaction started from IDLE.
    function automatic res_t model(input bit rw, input bit fetch, input bit hit, input int n_rdy);
        res_t e;
        e = '0;
        e.acc_t = 8'd1;
        e.wr_ok = 1'b1;
        e.idle_mreq_n = 1'b1;
        e.idle_stp = 1'b0;
        if (hit && !rw) begin
            e.dt_t = 8'd2; e.done_t = 8'd3; e.err_t = 8'hFF; e.dt_cnt = 8'd1;
            e.stall = 1'b0; e.fmiss = 1'b0;
            exp_hit++;
        end else begin
            e.stall = 1'b1; e.fmiss = fetch;
            exp_miss++;
            if (n_rdy >= 0 && n_rdy <= T - 1) begin
                e.dt_t = 8'(3 + n_rdy); e.done_t = 8'(4 + n_rdy); e.err_t = 8'hFF; e.dt_cnt = 8'd1;
            end else begin
                e.dt_t = 8'hFF; e.done_t = 8'hFF; e.err_t = 8'(2 + T); e.dt_cnt = 8'd0;
            end
        end
        e.hit_cnt  = cnt16(exp_hit);
        e.miss_cnt = cnt16(exp_miss);
        return e;
    endfunction

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Drives one request and records what the DUT does (no checking here).
    task automatic run_txn(input bit rw, input bit fetch, input bit hit, input int n_rdy,
                           output res_t o);
        int t;
        bit fin;
        int acc;
        o = '0;
        o.acc_t = 8'hFF; o.dt_t = 8'hFF; o.done_t = 8'hFF; o.err_t = 8'hFF;
        o.wr_ok = 1'b1;
        acc = -1;
        bus_if.MREQ_REQ = 1'b1; bus_if.RW_REQ = rw; bus_if.FETCH_REQ = fetch;
        bus_if.HIT = hit; bus_if.MEM_RDY_n = 1'b1;
        t = 0; fin = 1'b0;
        while (!fin && t < 200) begin
            tick();
            t++;
            if (bus_if.ACCEPT && acc < 0) begin
                acc = t; o.acc_t = 8'(t); bus_if.MREQ_REQ = 1'b0;
            end
            if (acc >= 0) begin
                if (!bus_if.DT_n) begin
                    o.dt_cnt++;
                    if (o.dt_t == 8'hFF) o.dt_t = 8'(t);
                end
                if (bus_if.STP) o.stall = 1'b1;
                if (bus_if.FMISS) o.fmiss = 1'b1;
                if (bus_if.WRITE !== rw || bus_if.FETCH !== fetch) o.wr_ok = 1'b0;
                if (bus_if.DONE) begin o.done_t = 8'(t); fin = 1'b1; end
                if (!bus_if.IOXERR_n) begin o.err_t = 8'(t); fin = 1'b1; end
                if (n_rdy >= 0 && t >= acc + 1 + n_rdy) bus_if.MEM_RDY_n = 1'b0;
            end
        end
        bus_if.MREQ_REQ = 1'b0;
        tick();
        bus_if.MEM_RDY_n = 1'b1;
        o.idle_mreq_n = bus_if.MREQ_n;
        o.idle_stp    = bus_if.STP;
        o.hit_cnt     = bus_if.HIT_CNT;
        o.miss_cnt    = bus_if.MISS_CNT;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; CYC_EN = 1'b1; MR_n = 1'b1;
        bus_if.MREQ_REQ = 1'b0; bus_if.RW_REQ = 1'b0; bus_if.FETCH_REQ = 1'b0;
        bus_if.HIT = 1'b0; bus_if.MEM_RDY_n = 1'b1; bus_if.DVACC_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (outs() !== 9'b001001001) begin
            errors++; $display("FAIL reset_outputs got %b want %b", outs(), 9'b001001001);
        end
        checks++;
        if ({bus_if.HIT_CNT, bus_if.MISS_CNT} !== 32'h0) begin
            errors++; $display("FAIL reset_counters got %h want 0", {bus_if.HIT_CNT, bus_if.MISS_CNT});
        end
        #2 sys_rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (outs() !== 9'b001001001) begin
            errors++; $display("FAIL post_reset_idle got %b want %b", outs(), 9'b001001001);
        end
    endtask

    task automatic test_read_hit();
        res_t o, e;
        sb.push_back(model(1'b0, 1'b1, 1'b1, -1));
        run_txn(1'b0, 1'b1, 1'b1, -1, o);
        e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL read_hit got %h want %h", o, e); end
        checks++;
        if (o.done_t !== 8'd3 || o.stall !== 1'b0) begin
            errors++; $display("FAIL read_hit_latency got done=%0d stp=%0d want done=3 stp=0", o.done_t, o.stall);
        end
    endtask

    task automatic test_fetch_miss();
        res_t o, e;
        // Ready after T-1 = 5 BUS ticks lands on the expiry tick: ready must win.
        sb.push_back(model(1'b0, 1'b1, 1'b0, 5));
        run_txn(1'b0, 1'b1, 1'b0, 5, o);
        e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL fetch_miss got %h want %h", o, e); end
        checks++;
        if (o.done_t !== 8'd9 || o.dt_cnt !== 8'd1 || o.fmiss !== 1'b1) begin
            errors++; $display("FAIL fetch_miss_timing got done=%0d dt=%0d fmiss=%0d want 9 1 1", o.done_t, o.dt_cnt, o.fmiss);
        end
    endtask

    task automatic test_write_hit();
        res_t o, e;
        sb.push_back(model(1'b1, 1'b0, 1'b1, 2));
        run_txn(1'b1, 1'b0, 1'b1, 2, o);
        e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL write_hit got %h want %h", o, e); end
        checks++;
        if (o.stall !== 1'b1 || o.done_t !== 8'd6) begin
            errors++; $display("FAIL write_hit_bus got stp=%0d done=%0d want 1 6", o.stall, o.done_t);
        end
    endtask

    task automatic test_timeout();
        res_t o, e;
        sb.push_back(model(1'b0, 1'b0, 1'b0, -1));
        run_txn(1'b0, 1'b0, 1'b0, -1, o);
        e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL timeout got %h want %h", o, e); end
        checks++;
        if (o.done_t !== 8'hFF || o.err_t !== 8'(2 + T) || o.idle_mreq_n !== 1'b1 || o.idle_stp !== 1'b0) begin
            errors++; $display("FAIL timeout_abort got done=%h err=%0d mreq_n=%0d stp=%0d want ff %0d 1 0",
                               o.done_t, o.err_t, o.idle_mreq_n, o.idle_stp, 2 + T);
        end
        // Ready one tick after expiry is too late.
        sb.push_back(model(1'b0, 1'b1, 1'b0, T));
        run_txn(1'b0, 1'b1, 1'b0, T, o);
        e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL timeout_late_ready got %h want %h", o, e); end
    endtask

    task automatic test_back_to_back();
        res_t o, e;
        bit rw, fetch, hit;
        int n;
        for (int i = 0; i < 10; i++) begin
            rw    = 1'($urandom_range(1, 0));
            fetch = 1'($urandom_range(1, 0));
            hit   = 1'($urandom_range(1, 0));
            n     = int'($urandom_range(T + 1, 0)) - 1;
            sb.push_back(model(rw, fetch, hit, n));
            run_txn(rw, fetch, hit, n, o);
            e = sb.pop_front();
            checks++;
            if (o !== e) begin
                errors++; $display("FAIL back_to_back[%0d] rw=%0d f=%0d h=%0d n=%0d got %h want %h",
                                   i, rw, fetch, hit, n, o, e);
            end
        end
    endtask

    task automatic test_dma_block_and_mr();
        res_t o, e;
        bit seen;
        bus_if.MREQ_REQ = 1'b1; bus_if.RW_REQ = 1'b0; bus_if.FETCH_REQ = 1'b1;
        bus_if.HIT = 1'b0; bus_if.DVACC_n = 1'b0; seen = 1'b0;
        repeat (10) begin
            tick();
            if (bus_if.ACCEPT) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL dma_block got accept=1 want 0"); end
        bus_if.DVACC_n = 1'b1;
        tick();
        checks++;
        if (bus_if.ACCEPT !== 1'b1) begin errors++; $display("FAIL dma_release got accept=%0d want 1", bus_if.ACCEPT); end
        bus_if.MREQ_REQ = 1'b0;
        bus_if.DVACC_n = 1'b0;
        tick();
        exp_miss++;
        checks++;
        if ({bus_if.STP, bus_if.FMISS, bus_if.MREQ_n} !== 3'b110) begin
            errors++; $display("FAIL enter_bus got %b want 110", {bus_if.STP, bus_if.FMISS, bus_if.MREQ_n});
        end
        tick();
        MR_n = 1'b0;
        tick();
        checks++;
        if (outs() !== 9'b001001001) begin
            errors++; $display("FAIL master_clear got %b want %b", outs(), 9'b001001001);
        end
        checks++;
        if (bus_if.HIT_CNT !== cnt16(exp_hit) || bus_if.MISS_CNT !== cnt16(exp_miss)) begin
            errors++; $display("FAIL mr_keeps_counters got %h/%h want %h/%h",
                               bus_if.HIT_CNT, bus_if.MISS_CNT, cnt16(exp_hit), cnt16(exp_miss));
        end
        MR_n = 1'b1;
        bus_if.DVACC_n = 1'b1;
        sb.push_back(model(1'b0, 1'b0, 1'b1, -1));
        run_txn(1'b0, 1'b0, 1'b1, -1, o);
        e = sb.pop_front();
        checks++;
        if (o !== e) begin errors++; $display("FAIL after_mr got %h want %h", o, e); end
    endtask

    task automatic test_cyc_en();
        logic [2:0] tab [8];
        // {ACCEPT, DONE, DT_n} after each edge; even edges enabled, odd held.
        tab = '{3'b101, 3'b101, 3'b000, 3'b000, 3'b011, 3'b011, 3'b001, 3'b001};
        bus_if.MREQ_REQ = 1'b1; bus_if.RW_REQ = 1'b0; bus_if.FETCH_REQ = 1'b0; bus_if.HIT = 1'b1;
        for (int k = 0; k < 8; k++) begin
            CYC_EN = (k % 2 == 0);
            tick();
            if (k == 0) bus_if.MREQ_REQ = 1'b0;
            checks++;
            if ({bus_if.ACCEPT, bus_if.DONE, bus_if.DT_n} !== tab[k]) begin
                errors++; $display("FAIL cyc_en_step[%0d] got %b want %b", k,
                                   {bus_if.ACCEPT, bus_if.DONE, bus_if.DT_n}, tab[k]);
            end
        end
        CYC_EN = 1'b1;
        exp_hit++;
        checks++;
        if (bus_if.HIT_CNT !== cnt16(exp_hit)) begin
            errors++; $display("FAIL cyc_en_hit_cnt got %h want %h", bus_if.HIT_CNT, cnt16(exp_hit));
        end
        // Asynchronous reset while in XFER.
        bus_if.MREQ_REQ = 1'b1; bus_if.FETCH_REQ = 1'b1;
        tick();
        bus_if.MREQ_REQ = 1'b0;
        tick();
        checks++;
        if ({bus_if.DT_n, bus_if.MREQ_n, bus_if.FETCH} !== 3'b001) begin
            errors++; $display("FAIL pre_async_xfer got %b want 001", {bus_if.DT_n, bus_if.MREQ_n, bus_if.FETCH});
        end
        #2 sys_rst_n = 1'b0;
        #1;
        exp_hit = 0; exp_miss = 0;
        checks++;
        if (outs() !== 9'b001001001) begin
            errors++; $display("FAIL async_reset got %b want %b", outs(), 9'b001001001);
        end
        checks++;
        if ({bus_if.HIT_CNT, bus_if.MISS_CNT} !== 32'h0) begin
            errors++; $display("FAIL async_reset_counters got %h want 0", {bus_if.HIT_CNT, bus_if.MISS_CNT});
        end
        repeat (2) tick();
        checks++;
        if (bus_if.DONE !== 1'b0 || bus_if.IOXERR_n !== 1'b1) begin
            errors++; $display("FAIL async_no_done got done=%0d ioxerr_n=%0d want 0 1", bus_if.DONE, bus_if.IOXERR_n);
        end
        #2 sys_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_fetch_miss();
        test_write_hit();
        test_timeout();
        test_back_to_back();
        test_dma_block_and_mr();
        test_cyc_en();
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
